// File: rtl/alu_op_issue.sv
// Command sequencer for the add/subtract execution unit: issues one tagged
// operation at a time, waits out the unit's fixed latency and returns the result.
module alu_op_issue #(
  parameter int IN_WL   = 15,
  parameter int OUT_WL  = 16,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IN_WL-1:0]  cmd_a,
  input  logic [IN_WL-1:0]  cmd_b,
  input  logic              cmd_op,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [IN_WL-1:0]  exec_a,
  output logic [IN_WL-1:0]  exec_b,
  output logic              exec_add_nsub,
  input  logic [OUT_WL-1:0] exec_r,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OUT_WL-1:0] rsp_r,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  // LATENCY is limited to 1..15, so four bits always hold the wait count.
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [TAG_W-1:0]    tag_q;
  logic [IN_WL-1:0]    exec_a_q;
  logic [IN_WL-1:0]    exec_b_q;
  logic                exec_add_nsub_q;
  logic [OUT_WL-1:0]   rsp_r_q;
  logic [TAG_W-1:0]    rsp_tag_q;
  logic [CNT_W-1:0]    op_count_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                busy_q;

  logic                cmd_fire_s;
  logic                rsp_fire_s;

  // Handshake qualifiers for the two valid/ready interfaces.
  always_comb begin
    cmd_fire_s = cmd_valid & cmd_ready_q;
    rsp_fire_s = rsp_valid_q & rsp_ready;
  end

  // Sequencer FSM; the status flags are kept as registers alongside the state.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q         <= ST_IDLE;
      wcnt_q          <= {WCNT_W{1'b0}};
      tag_q           <= {TAG_W{1'b0}};
      exec_a_q        <= {IN_WL{1'b0}};
      exec_b_q        <= {IN_WL{1'b0}};
      exec_add_nsub_q <= 1'b0;
      rsp_r_q         <= {OUT_WL{1'b0}};
      rsp_tag_q       <= {TAG_W{1'b0}};
      op_count_q      <= {CNT_W{1'b0}};
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            exec_a_q        <= cmd_a;
            exec_b_q        <= cmd_b;
            exec_add_nsub_q <= cmd_op;
            tag_q           <= cmd_tag;
            wcnt_q          <= WCNT_W'(LATENCY);
            state_q         <= ST_WAIT;
            cmd_ready_q     <= 1'b0;
            busy_q          <= 1'b1;
          end
        end
        ST_WAIT: begin
          // The unit output is only valid one edge after the count drains.
          if (wcnt_q != {WCNT_W{1'b0}}) begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end else begin
            rsp_r_q     <= exec_r;
            rsp_tag_q   <= tag_q;
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_fire_s) begin
            state_q     <= ST_IDLE;
            op_count_q  <= op_count_q + CNT_W'(1);
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          wcnt_q      <= {WCNT_W{1'b0}};
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_r         = rsp_r_q;
  assign rsp_tag       = rsp_tag_q;
  assign op_count      = op_count_q;
  assign exec_a        = exec_a_q;
  assign exec_b        = exec_b_q;
  assign exec_add_nsub = exec_add_nsub_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: three instances (LATENCY 1, 2, 3) share the
// command/response stimulus, each fed by its own pipelined add/sub unit model.
module tb_alu_op_issue;

  logic        clk;
  logic        rstb;
  logic        cmd_valid;
  logic        cmd_op;
  logic        rsp_ready;
  logic [14:0] cmd_a;
  logic [14:0] cmd_b;
  logic [3:0]  cmd_tag;

  logic        cmd_ready_1, cmd_ready_2, cmd_ready_3;
  logic [14:0] exec_a_1, exec_a_2, exec_a_3;
  logic [14:0] exec_b_1, exec_b_2, exec_b_3;
  logic        exec_add_nsub_1, exec_add_nsub_2, exec_add_nsub_3;
  logic [15:0] exec_r_1, exec_r_2, exec_r_3;
  logic        rsp_valid_1, rsp_valid_2, rsp_valid_3;
  logic [15:0] rsp_r_1, rsp_r_2, rsp_r_3;
  logic [3:0]  rsp_tag_1, rsp_tag_2, rsp_tag_3;
  logic        busy_1, busy_2, busy_3;
  logic [7:0]  op_count_1, op_count_2;
  logic [3:0]  op_count_3;

  logic [15:0] pipe1 [1];
  logic [15:0] pipe2 [2];
  logic [15:0] pipe3 [3];

  int pass_cnt;
  int total_cnt;

  alu_op_issue #(.IN_WL(15), .OUT_WL(16), .LATENCY(1), .TAG_W(4), .CNT_W(8)) u_l1 (
    .clk(clk), .rstb(rstb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_1),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .exec_a(exec_a_1), .exec_b(exec_b_1), .exec_add_nsub(exec_add_nsub_1),
    .exec_r(exec_r_1), .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r_1), .rsp_tag(rsp_tag_1), .busy(busy_1), .op_count(op_count_1)
  );

  alu_op_issue #(.IN_WL(15), .OUT_WL(16), .LATENCY(2), .TAG_W(4), .CNT_W(8)) u_l2 (
    .clk(clk), .rstb(rstb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .exec_a(exec_a_2), .exec_b(exec_b_2), .exec_add_nsub(exec_add_nsub_2),
    .exec_r(exec_r_2), .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r_2), .rsp_tag(rsp_tag_2), .busy(busy_2), .op_count(op_count_2)
  );

  alu_op_issue #(.IN_WL(15), .OUT_WL(16), .LATENCY(3), .TAG_W(4), .CNT_W(4)) u_l3 (
    .clk(clk), .rstb(rstb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .exec_a(exec_a_3), .exec_b(exec_b_3), .exec_add_nsub(exec_add_nsub_3),
    .exec_r(exec_r_3), .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r_3), .rsp_tag(rsp_tag_3), .busy(busy_3), .op_count(op_count_3)
  );

  function automatic logic [15:0] eu(input logic [14:0] a, input logic [14:0] b, input logic add);
    return add ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execution-unit models: LATENCY registered stages each.
  always_ff @(posedge clk) begin
    pipe1[0] <= eu(exec_a_1, exec_b_1, exec_add_nsub_1);
    pipe2[0] <= eu(exec_a_2, exec_b_2, exec_add_nsub_2);
    pipe2[1] <= pipe2[0];
    pipe3[0] <= eu(exec_a_3, exec_b_3, exec_add_nsub_3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign exec_r_1 = pipe1[0];
  assign exec_r_2 = pipe2[1];
  assign exec_r_3 = pipe3[2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstb = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick; tick;
    rstb = 1'b1;
  endtask

  task automatic set_cmd(input logic [14:0] a, input logic [14:0] b, input logic op, input logic [3:0] tag);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
  endtask

  // Drives one command into the LATENCY=2 instance and collects its response.
  task automatic run_op2(input logic [14:0] a, input logic [14:0] b, input logic op,
                         input logic [3:0] tag, output logic [15:0] r, output logic [3:0] t);
    int n;
    r = 16'hxxxx; t = 4'hx;
    set_cmd(a, b, op, tag);
    tick;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid_2 && n < 20) begin tick; n++; end
    if (rsp_valid_2) begin r = rsp_r_2; t = rsp_tag_2; end
    rsp_ready = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    set_cmd(15'd9, 15'd9, 1'b1, 4'hF);
    rstb = 1'b0;
    tick;
    total_cnt++; if (cmd_ready_2 !== 1'b1) $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready_2); else pass_cnt++;
    total_cnt++; if (busy_2 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_2); else pass_cnt++;
    total_cnt++; if (rsp_valid_2 !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid_2); else pass_cnt++;
    total_cnt++; if (exec_a_2 !== 15'd0) $display("FAIL reset_exec_a got %h exp 0", exec_a_2); else pass_cnt++;
    total_cnt++; if (exec_b_2 !== 15'd0 || exec_add_nsub_2 !== 1'b0) $display("FAIL reset_exec_b_op got %h/%b exp 0/0", exec_b_2, exec_add_nsub_2); else pass_cnt++;
    total_cnt++; if (rsp_r_2 !== 16'd0 || rsp_tag_2 !== 4'd0) $display("FAIL reset_rsp got %h/%h exp 0/0", rsp_r_2, rsp_tag_2); else pass_cnt++;
    total_cnt++; if (op_count_2 !== 8'd0) $display("FAIL reset_op_count got %0d exp 0", op_count_2); else pass_cnt++;
    cmd_valid = 1'b0;
    rstb = 1'b1;
  endtask

  task automatic test_add;
    do_reset;
    set_cmd(15'd5, 15'd3, 1'b1, 4'h3);
    tick;
    cmd_valid = 1'b0;
    total_cnt++; if (exec_a_2 !== 15'd5 || exec_b_2 !== 15'd3 || exec_add_nsub_2 !== 1'b1)
      $display("FAIL add_exec got %0d/%0d/%b exp 5/3/1", exec_a_2, exec_b_2, exec_add_nsub_2); else pass_cnt++;
    total_cnt++; if (cmd_ready_2 !== 1'b0 || busy_2 !== 1'b1) $display("FAIL add_busy got rdy %b busy %b exp 0/1", cmd_ready_2, busy_2); else pass_cnt++;
    tick; tick;
    total_cnt++; if (rsp_valid_2 !== 1'b0) $display("FAIL add_early_valid got %b exp 0", rsp_valid_2); else pass_cnt++;
    tick;
    total_cnt++; if (rsp_valid_2 !== 1'b1) $display("FAIL add_valid_e3 got %b exp 1", rsp_valid_2); else pass_cnt++;
    total_cnt++; if (rsp_r_2 !== 16'd8) $display("FAIL add_rsp_r got %h exp 0008", rsp_r_2); else pass_cnt++;
    total_cnt++; if (rsp_tag_2 !== 4'h3) $display("FAIL add_rsp_tag got %h exp 3", rsp_tag_2); else pass_cnt++;
    tick;
    total_cnt++; if (op_count_2 !== 8'd1) $display("FAIL add_op_count got %0d exp 1", op_count_2); else pass_cnt++;
    total_cnt++; if (rsp_valid_2 !== 1'b0 || cmd_ready_2 !== 1'b1) $display("FAIL add_idle got vld %b rdy %b exp 0/1", rsp_valid_2, cmd_ready_2); else pass_cnt++;
    total_cnt++; if (exec_a_2 !== 15'd5) $display("FAIL add_exec_hold got %0d exp 5", exec_a_2); else pass_cnt++;
  endtask

  task automatic test_subtract;
    logic [15:0] r;
    logic [3:0]  t;
    do_reset;
    run_op2(15'd3, 15'd10, 1'b0, 4'h1, r, t);
    total_cnt++; if (r !== 16'hFFF9) $display("FAIL sub_wrap got %h exp fff9", r); else pass_cnt++;
    total_cnt++; if (t !== 4'h1) $display("FAIL sub_wrap_tag got %h exp 1", t); else pass_cnt++;
    run_op2(15'd10, 15'd3, 1'b0, 4'h2, r, t);
    total_cnt++; if (r !== 16'h0007) $display("FAIL sub_plain got %h exp 0007", r); else pass_cnt++;
    total_cnt++; if (op_count_2 !== 8'd2) $display("FAIL sub_op_count got %0d exp 2", op_count_2); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int n;
    do_reset;
    rsp_ready = 1'b0;
    set_cmd(15'd100, 15'd1, 1'b1, 4'h5);
    tick;
    set_cmd(15'd7, 15'd2, 1'b0, 4'h9);
    n = 0;
    while (!rsp_valid_2 && n < 10) begin tick; n++; end
    total_cnt++; if (rsp_valid_2 !== 1'b1) $display("FAIL bp_valid_timeout got %b exp 1", rsp_valid_2); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick;
      total_cnt++; if (rsp_valid_2 !== 1'b1 || rsp_r_2 !== 16'd101 || rsp_tag_2 !== 4'h5 || cmd_ready_2 !== 1'b0)
        $display("FAIL bp_hold cyc %0d got vld %b r %h tag %h rdy %b exp 1/0065/5/0", i, rsp_valid_2, rsp_r_2, rsp_tag_2, cmd_ready_2);
      else pass_cnt++;
    end
    total_cnt++; if (exec_a_2 !== 15'd100) $display("FAIL bp_no_accept got %0d exp 100", exec_a_2); else pass_cnt++;
    rsp_ready = 1'b1;
    tick;
    total_cnt++; if (cmd_ready_2 !== 1'b1 || exec_a_2 !== 15'd100 || op_count_2 !== 8'd1)
      $display("FAIL bp_release got rdy %b a %0d cnt %0d exp 1/100/1", cmd_ready_2, exec_a_2, op_count_2); else pass_cnt++;
    tick;
    cmd_valid = 1'b0;
    total_cnt++; if (exec_a_2 !== 15'd7 || exec_add_nsub_2 !== 1'b0) $display("FAIL bp_second_accept got %0d/%b exp 7/0", exec_a_2, exec_add_nsub_2); else pass_cnt++;
    n = 0;
    while (!rsp_valid_2 && n < 10) begin tick; n++; end
    total_cnt++; if (rsp_r_2 !== 16'd5 || rsp_tag_2 !== 4'h9) $display("FAIL bp_second_rsp got %h/%h exp 0005/9", rsp_r_2, rsp_tag_2); else pass_cnt++;
    tick;
  endtask

  task automatic test_reset_mid_wait;
    logic [15:0] r;
    logic [3:0]  t;
    bit          seen;
    do_reset;
    run_op2(15'd20, 15'd22, 1'b1, 4'h6, r, t);
    total_cnt++; if (r !== 16'd42 || op_count_2 !== 8'd1) $display("FAIL rmw_pre got %0d cnt %0d exp 42/1", r, op_count_2); else pass_cnt++;
    set_cmd(15'd11, 15'd1, 1'b1, 4'h7);
    tick;
    cmd_valid = 1'b0;
    total_cnt++; if (exec_a_2 !== 15'd11) $display("FAIL rmw_accept got %0d exp 11", exec_a_2); else pass_cnt++;
    rstb = 1'b0;
    tick;
    rstb = 1'b1;
    total_cnt++; if (cmd_ready_2 !== 1'b1 || busy_2 !== 1'b0) $display("FAIL rmw_ready got %b/%b exp 1/0", cmd_ready_2, busy_2); else pass_cnt++;
    total_cnt++; if (exec_a_2 !== 15'd0) $display("FAIL rmw_exec_a got %0d exp 0", exec_a_2); else pass_cnt++;
    total_cnt++; if (op_count_2 !== 8'd0) $display("FAIL rmw_op_count got %0d exp 0", op_count_2); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid_2 === 1'b1) seen = 1'b1;
      tick;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL rmw_no_rsp got %b exp 0", seen); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_q[$];
    logic [3:0]  tag_q[$];
    logic [15:0] e;
    logic [3:0]  et;
    int issued, done, last_acc;
    bit acc, hs;
    do_reset;
    issued = 0; done = 0; last_acc = -1;
    set_cmd(15'($urandom_range(32767, 0)), 15'($urandom_range(32767, 0)), 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
    for (int cyc = 0; cyc < 400 && done < 20; cyc++) begin
      acc = cmd_valid && cmd_ready_3;
      hs  = rsp_valid_3 && rsp_ready;
      if (hs) begin
        e = 16'hxxxx; et = 4'hx;
        if (exp_q.size() > 0) begin e = exp_q.pop_front(); et = tag_q.pop_front(); end
        total_cnt++; if (rsp_r_3 !== e) $display("FAIL b2b_r #%0d got %h exp %h", done, rsp_r_3, e); else pass_cnt++;
        total_cnt++; if (rsp_tag_3 !== et) $display("FAIL b2b_tag #%0d got %h exp %h", done, rsp_tag_3, et); else pass_cnt++;
        done++;
      end
      if (acc) begin
        exp_q.push_back(eu(cmd_a, cmd_b, cmd_op));
        tag_q.push_back(cmd_tag);
        if (last_acc >= 0) begin
          total_cnt++; if (cyc - last_acc !== 6) $display("FAIL b2b_spacing got %0d exp 6", cyc - last_acc); else pass_cnt++;
        end
        last_acc = cyc;
        issued++;
      end
      tick;
      if (acc) begin
        if (issued < 20)
          set_cmd(15'($urandom_range(32767, 0)), 15'($urandom_range(32767, 0)), 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
        else
          cmd_valid = 1'b0;
      end
    end
    total_cnt++; if (done !== 20) $display("FAIL b2b_done got %0d exp 20", done); else pass_cnt++;
    total_cnt++; if (op_count_3 !== 4'd4) $display("FAIL b2b_op_count_wrap got %0d exp 4", op_count_3); else pass_cnt++;
  endtask

  task automatic test_latency1;
    int n;
    do_reset;
    set_cmd(15'd1, 15'd1, 1'b1, 4'h1);
    tick;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid_1 && n < 10) begin tick; n++; end
    total_cnt++; if (rsp_r_1 !== 16'd2) $display("FAIL l1_pre got %h exp 0002", rsp_r_1); else pass_cnt++;
    tick;
    set_cmd(15'h7FFF, 15'h7FFF, 1'b1, 4'hA);
    tick;
    cmd_valid = 1'b0;
    total_cnt++; if (rsp_valid_1 !== 1'b0) $display("FAIL l1_valid_e0 got %b exp 0", rsp_valid_1); else pass_cnt++;
    tick;
    total_cnt++; if (rsp_valid_1 !== 1'b0) $display("FAIL l1_valid_e1 got %b exp 0", rsp_valid_1); else pass_cnt++;
    tick;
    total_cnt++; if (rsp_valid_1 !== 1'b1) $display("FAIL l1_valid_e2 got %b exp 1", rsp_valid_1); else pass_cnt++;
    total_cnt++; if (rsp_r_1 !== 16'hFFFE || rsp_tag_1 !== 4'hA) $display("FAIL l1_rsp got %h/%h exp fffe/a", rsp_r_1, rsp_tag_1); else pass_cnt++;
    tick;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rstb = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_a = 15'd0; cmd_b = 15'd0; cmd_op = 1'b0; cmd_tag = 4'd0;
    tick;
    test_reset;
    test_add;
    test_subtract;
    test_backpressure;
    test_reset_mid_wait;
    test_back_to_back;
    test_latency1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
